// File: rtl/disp_tx_pkg.sv
// Shared types and helpers for the display shift-register transmitter.
// pack_frame works on a fixed MAX_DIGITS width; callers zero-extend and truncate.
package disp_tx_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } tx_state_t;

    localparam int unsigned DIGIT_FRAME_W = 8;
    localparam int unsigned MAX_DIGITS    = 16;

    // Digit i occupies frame byte i: {3'b000, dp, bcd}; BCD values above 9 pass through.
    function automatic logic [MAX_DIGITS*DIGIT_FRAME_W-1:0] pack_frame(
        input logic [MAX_DIGITS*4-1:0] bcd,
        input logic [MAX_DIGITS-1:0]   dp
    );
        logic [MAX_DIGITS*DIGIT_FRAME_W-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            f[i*DIGIT_FRAME_W +: DIGIT_FRAME_W] = {3'b000, dp[i], bcd[i*4 +: 4]};
        end
        return f;
    endfunction

endpackage

// File: rtl/disp_tx_phase_timer.sv
// Loadable down-counter; phase_end marks the last cycle of a timed phase.
// A load in a cycle counts as that phase's first cycle, so load_val = cycles - 1.
module disp_tx_phase_timer #(
    parameter int unsigned TMR_W = 2
) (
    input  logic             g_clk,
    input  logic             g_nrst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             phase_end
);
    logic [TMR_W-1:0] count;
    logic [TMR_W-1:0] count_eff;

    always_comb begin
        count_eff = load ? load_val : count;
        phase_end = (count_eff == '0);
    end

    always_ff @(posedge g_clk or negedge g_nrst) begin
        if (!g_nrst) begin
            count <= '0;
        end else if (phase_end) begin
            count <= '0;
        end else begin
            count <= count_eff - 1'b1;
        end
    end

endmodule

// File: rtl/disp_shift_tx.sv
// Serialises a digit/decimal-point/control snapshot into the display shift chains
// and pulses the register clock; NUM_DIGITS must not exceed disp_tx_pkg::MAX_DIGITS.
module disp_shift_tx
    import disp_tx_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic                    g_clk,
    input  logic                    g_nrst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_DIGITS*4-1:0] digit_bcd,
    input  logic [NUM_DIGITS-1:0]   digit_dp,
    input  logic [7:0]              ctrl_byte,
    input  logic                    clr,
    output logic                    done,
    output logic                    ser_clk,
    output logic                    ser_nrst,
    output logic                    digit_ser,
    output logic                    ctrl_ser,
    output logic                    latch_clk
);
    localparam int unsigned TOTAL    = NUM_DIGITS * DIGIT_FRAME_W;
    localparam int unsigned IDX_W    = $clog2(TOTAL + 1);
    localparam int unsigned TMR_MAX  = (CLR_CYCLES > CLK_DIV) ? CLR_CYCLES : CLK_DIV;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);

    tx_state_t        state, next_state;
    logic             entry_q;
    logic [IDX_W-1:0] idx;
    logic [TOTAL-1:0] frame;
    logic [7:0]       ctrl_q;
    logic [TOTAL-1:0] frame_d;
    logic [TMR_W-1:0] tmr_val;
    logic             phase_end;
    logic             accept;
    logic             data_bit;
    logic             ctrl_bit;

    // Reset counts as a state entry, so CLEAR is timed from the first cycle after release.
    disp_tx_phase_timer #(.TMR_W(TMR_W)) u_timer (
        .g_clk    (g_clk),
        .g_nrst   (g_nrst),
        .load     (entry_q),
        .load_val (tmr_val),
        .phase_end(phase_end)
    );

    always_comb begin
        frame_d  = TOTAL'(pack_frame((MAX_DIGITS*4)'(digit_bcd), MAX_DIGITS'(digit_dp)));
        data_bit = frame[idx];
        ctrl_bit = (idx < IDX_W'(8)) ? ctrl_q[idx[2:0]] : 1'b0;
    end

    always_comb begin
        next_state = state;
        tmr_val    = DIV_LOAD;
        load_ready = 1'b0;
        accept     = 1'b0;
        ser_clk    = 1'b0;
        ser_nrst   = 1'b1;
        latch_clk  = 1'b0;
        digit_ser  = 1'b0;
        ctrl_ser   = 1'b0;
        case (state)
            CLEAR: begin
                ser_nrst = 1'b0;
                tmr_val  = CLR_LOAD;
                if (phase_end) next_state = IDLE;
            end
            IDLE: begin
                load_ready = !clr;
                if (clr) begin
                    next_state = CLEAR;
                end else if (load_valid) begin
                    accept     = 1'b1;
                    next_state = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                digit_ser = data_bit;
                ctrl_ser  = ctrl_bit;
                if (phase_end) next_state = SHIFT_HI;
            end
            SHIFT_HI: begin
                ser_clk   = 1'b1;
                digit_ser = data_bit;
                ctrl_ser  = ctrl_bit;
                if (phase_end) next_state = (idx == '0) ? LATCH_HI : SHIFT_LO;
            end
            LATCH_HI: begin
                latch_clk = 1'b1;
                if (phase_end) next_state = LATCH_LO;
            end
            LATCH_LO: begin
                if (phase_end) next_state = IDLE;
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_nrst) begin
        if (!g_nrst) begin
            state   <= CLEAR;
            entry_q <= 1'b1;
            done    <= 1'b0;
            idx     <= '0;
            frame   <= '0;
            ctrl_q  <= '0;
        end else begin
            state   <= next_state;
            entry_q <= (next_state != state);
            done    <= (state == LATCH_LO) && (next_state == IDLE);
            if (accept) begin
                idx    <= IDX_W'(TOTAL - 1);
                frame  <= frame_d;
                ctrl_q <= ctrl_byte;
            end else if (state == SHIFT_HI && phase_end && idx != '0) begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_shift_tx.sv
// Bench for disp_shift_tx: table-driven frames through a 74HC595-style chain model,
// plus sequences for held valid, clr priority, mid-frame reset and CLK_DIV=1.
module tb_disp_shift_tx;

    logic        g_clk = 1'b0;
    logic        g_nrst;
    always #5 g_clk = ~g_clk;

    // Instance 0: defaults; instance 1: CLK_DIV=1
    logic        load_valid0, load_ready0, clr0, done0, ser_clk0, ser_nrst0, digit_ser0, ctrl_ser0, latch_clk0;
    logic [23:0] bcd0;
    logic [5:0]  dp0;
    logic [7:0]  ctrl0;
    logic        load_valid1, load_ready1, clr1, done1, ser_clk1, ser_nrst1, digit_ser1, ctrl_ser1, latch_clk1;
    logic [23:0] bcd1;
    logic [5:0]  dp1;
    logic [7:0]  ctrl1;

    disp_shift_tx #(.NUM_DIGITS(6), .CLK_DIV(2), .CLR_CYCLES(4)) dut0 (
        .g_clk(g_clk), .g_nrst(g_nrst), .load_valid(load_valid0), .load_ready(load_ready0),
        .digit_bcd(bcd0), .digit_dp(dp0), .ctrl_byte(ctrl0), .clr(clr0), .done(done0),
        .ser_clk(ser_clk0), .ser_nrst(ser_nrst0), .digit_ser(digit_ser0), .ctrl_ser(ctrl_ser0),
        .latch_clk(latch_clk0)
    );

    disp_shift_tx #(.NUM_DIGITS(6), .CLK_DIV(1), .CLR_CYCLES(4)) dut1 (
        .g_clk(g_clk), .g_nrst(g_nrst), .load_valid(load_valid1), .load_ready(load_ready1),
        .digit_bcd(bcd1), .digit_dp(dp1), .ctrl_byte(ctrl1), .clr(clr1), .done(done1),
        .ser_clk(ser_clk1), .ser_nrst(ser_nrst1), .digit_ser(digit_ser1), .ctrl_ser(ctrl_ser1),
        .latch_clk(latch_clk1)
    );

    // External shift-register chain model: data enters the register nearest the FPGA.
    logic [47:0] sr0 = '0, q0 = '0, sr1 = '0, q1 = '0;
    logic [7:0]  csr0 = '0, cq0 = '0, csr1 = '0, cq1 = '0;
    int          latch_cnt0 = 0, rise0 = 0, acc0 = 0, per1 = 0;
    longint      last1 = 0;

    always @(posedge ser_clk0 or negedge ser_nrst0)
        if (!ser_nrst0) begin sr0 <= '0; csr0 <= '0; end
        else begin sr0 <= {sr0[46:0], digit_ser0}; csr0 <= {csr0[6:0], ctrl_ser0}; end
    always @(posedge latch_clk0) begin q0 <= sr0; cq0 <= csr0; latch_cnt0 <= latch_cnt0 + 1; end
    always @(posedge ser_clk1 or negedge ser_nrst1)
        if (!ser_nrst1) begin sr1 <= '0; csr1 <= '0; end
        else begin sr1 <= {sr1[46:0], digit_ser1}; csr1 <= {csr1[6:0], ctrl_ser1}; end
    always @(posedge latch_clk1) begin q1 <= sr1; cq1 <= csr1; end

    always @(posedge ser_clk0) rise0 = rise0 + 1;
    always @(posedge ser_clk1) begin per1 = int'(($time - last1) / 10); last1 = $time; end
    always @(posedge g_clk) if (load_valid0 && load_ready0) acc0 = acc0 + 1;

    // Setup/hold and latch ordering monitor for both instances
    logic [1:0] sk, lk, ds, cs, pk = '0, pl = '0, pd = '0, pc = '0;
    int div_of[2] = '{2, 1};
    int viol[2]   = '{0, 0};
    int stab[2]   = '{1000, 1000};
    int since[2]  = '{1000, 1000};
    assign sk = {ser_clk1, ser_clk0};
    assign lk = {latch_clk1, latch_clk0};
    assign ds = {digit_ser1, digit_ser0};
    assign cs = {ctrl_ser1, ctrl_ser0};

    always @(negedge g_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stab[i] < 1000) stab[i] = stab[i] + 1;
            if (since[i] < 1000) since[i] = since[i] + 1;
            if (g_nrst) begin
                if (ds[i] != pd[i] || cs[i] != pc[i]) begin
                    if (sk[i] && pk[i]) viol[i] = viol[i] + 1;
                    if (since[i] < div_of[i]) viol[i] = viol[i] + 1;
                    stab[i] = 0;
                end
                if (sk[i] && !pk[i] && stab[i] < div_of[i]) viol[i] = viol[i] + 1;
                if (lk[i] && !pl[i] && sk[i]) viol[i] = viol[i] + 1;
            end
            if (sk[i] && !pk[i]) since[i] = 0;
        end
        pk = sk; pl = lk; pd = ds; pc = cs;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one frame, drop valid and scramble inputs after accept; lat = cycles from accept to done.
    task automatic run_frame(input bit sel, input logic [23:0] b, input logic [5:0] d,
                             input logic [7:0] c, output int lat);
        int n;
        @(negedge g_clk);
        if (sel) begin bcd1 = b; dp1 = d; ctrl1 = c; load_valid1 = 1'b1; end
        else     begin bcd0 = b; dp0 = d; ctrl0 = c; load_valid0 = 1'b1; end
        n = 0;
        while (!(sel ? load_ready1 : load_ready0) && n < 100) begin @(negedge g_clk); n++; end
        @(negedge g_clk);
        if (sel) begin load_valid1 = 1'b0; bcd1 = ~b; dp1 = ~d; ctrl1 = ~c; end
        else     begin load_valid0 = 1'b0; bcd0 = ~b; dp0 = ~d; ctrl0 = ~c; end
        lat = 1;
        while (!(sel ? done1 : done0) && lat < 1000) begin @(negedge g_clk); lat++; end
    endtask

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  dp;
        logic [7:0]  ctrl;
        logic [47:0] exp_q;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int n, lat, a0, lbase;
        vecs[0] = '{24'h654321, 6'b000100, 8'hA5, 48'h060504130201};
        vecs[1] = '{24'h000000, 6'b111111, 8'h00, 48'h101010101010};
        vecs[2] = '{24'h987654, 6'b100001, 8'h3C, 48'h190807060514};
        vecs[3] = '{24'hFFFFFF, 6'b000000, 8'hFF, 48'h0F0F0F0F0F0F};

        g_nrst = 1'b0;
        load_valid0 = 0; clr0 = 0; bcd0 = '0; dp0 = '0; ctrl0 = '0;
        load_valid1 = 0; clr1 = 0; bcd1 = '0; dp1 = '0; ctrl1 = '0;
        repeat (3) @(negedge g_clk);
        check("rst_out0", {ser_nrst0, ser_clk0, latch_clk0, digit_ser0, ctrl_ser0, load_ready0, done0}, 0);
        check("rst_out1", {ser_nrst1, ser_clk1, latch_clk1, digit_ser1, ctrl_ser1, load_ready1, done1}, 0);

        g_nrst = 1'b1;
        n = 0;
        while (!ser_nrst0 && n < 20) begin @(negedge g_clk); n++; end
        check("clr_len_rst", n, 4);
        check("ready_after_clr", load_ready0, 1);
        check("idle_quiet", {ser_clk0, latch_clk0, digit_ser0, ctrl_ser0, done0}, 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(1'b0, vecs[i].bcd, vecs[i].dp, vecs[i].ctrl, lat);
            check($sformatf("lat_v%0d", i), lat, 197);
            check($sformatf("digits_v%0d", i), q0, vecs[i].exp_q);
            check($sformatf("ctrl_v%0d", i), cq0, vecs[i].ctrl);
        end

        // Valid held across two frames with data changing mid-frame
        @(negedge g_clk);
        a0 = acc0;
        bcd0 = vecs[0].bcd; dp0 = vecs[0].dp; ctrl0 = vecs[0].ctrl; load_valid0 = 1'b1;
        @(negedge g_clk);
        bcd0 = vecs[2].bcd; dp0 = vecs[2].dp; ctrl0 = vecs[2].ctrl;
        n = 0;
        while (!done0 && n < 400) begin @(negedge g_clk); n++; end
        check("hold_acc1", acc0 - a0, 1);
        check("hold_q1", q0, vecs[0].exp_q);
        check("hold_ready_at_done", load_ready0, 1);
        @(negedge g_clk);
        bcd0 = vecs[1].bcd; dp0 = vecs[1].dp; ctrl0 = vecs[1].ctrl;
        n = 0;
        while (!done0 && n < 400) begin @(negedge g_clk); n++; end
        load_valid0 = 1'b0;
        check("hold_acc2", acc0 - a0, 2);
        check("hold_q2", q0, vecs[2].exp_q);
        check("hold_c2", cq0, vecs[2].ctrl);
        @(negedge g_clk);
        check("hold_no_extra", acc0 - a0, 2);

        // clr wins over a simultaneous load_valid
        a0 = acc0;
        bcd0 = vecs[1].bcd; dp0 = vecs[1].dp; ctrl0 = vecs[1].ctrl;
        clr0 = 1'b1; load_valid0 = 1'b1;
        #1 check("clr_blocks_ready", load_ready0, 0);
        @(negedge g_clk);
        clr0 = 1'b0;
        n = 0;
        while (!ser_nrst0 && n < 20) begin @(negedge g_clk); n++; end
        load_valid0 = 1'b0;
        check("clr_len", n, 4);
        check("clr_no_accept", acc0 - a0, 0);
        run_frame(1'b0, vecs[0].bcd, vecs[0].dp, vecs[0].ctrl, lat);
        check("after_clr_lat", lat, 197);
        check("after_clr_q", q0, vecs[0].exp_q);

        // Reset in the middle of a frame
        @(negedge g_clk);
        bcd0 = vecs[2].bcd; dp0 = vecs[2].dp; ctrl0 = vecs[2].ctrl; load_valid0 = 1'b1;
        @(negedge g_clk);
        load_valid0 = 1'b0;
        a0 = rise0;
        lbase = latch_cnt0;
        n = 0;
        while (rise0 - a0 < 20 && n < 500) begin @(negedge g_clk); n++; end
        check("reached_bit20", rise0 - a0, 20);
        g_nrst = 1'b0;
        #1 check("midrst_out", {ser_nrst0, ser_clk0, latch_clk0, digit_ser0, ctrl_ser0, load_ready0, done0}, 0);
        repeat (3) @(negedge g_clk);
        g_nrst = 1'b1;
        n = 0;
        while (!ser_nrst0 && n < 20) begin @(negedge g_clk); n++; end
        check("midrst_clr_len", n, 4);
        check("midrst_chain_zero", {sr0, csr0}, 0);
        check("midrst_no_latch", latch_cnt0 - lbase, 0);

        // CLK_DIV=1 with an out-of-range BCD digit
        run_frame(1'b1, 24'h00F000, 6'b000000, 8'h81, lat);
        check("div1_lat", lat, 99);
        check("div1_q", q1, 48'h00000F000000);
        check("div1_ctrl", cq1, 8'h81);
        check("div1_invalid3", q1[27:24] > 4'd9, 1);
        check("div1_period", per1, 2);

        check("timing_div2", viol[0], 0);
        check("timing_div1", viol[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
